// File: rtl/iq_demod_seq.sv
// iq_demod_seq: LO quarter-phase sequencer and I/Q integrate-and-dump chip controller
module iq_demod_seq #(
    parameter int DIV            = 5,
    parameter int STEPS_PER_CHIP = 4,
    parameter int NCHIP_W        = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sample_valid,
    input  logic               start,
    input  logic               abort,
    input  logic [NCHIP_W-1:0] n_chips,
    output logic [1:0]         lo_phase,
    output logic               lo_en,
    output logic               integ_en,
    output logic               integ_clr,
    output logic               chip_valid,
    input  logic               chip_ready,
    output logic [NCHIP_W-1:0] chip_idx,
    output logic               overrun,
    output logic               busy,
    output logic               done
);
    localparam int SW = $clog2(DIV + 1);
    localparam int TW = $clog2(STEPS_PER_CHIP + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [SW-1:0]      sample_cnt;
    logic [TW-1:0]      step_cnt;
    logic [NCHIP_W-1:0] chip_cnt, n_lat;
    logic               step_end, chip_end, last_chip;

    assign integ_en  = state == RUN && sample_valid;
    assign integ_clr = integ_en && sample_cnt == '0 && step_cnt == '0;
    assign step_end  = integ_en && sample_cnt == SW'(DIV - 1);
    assign chip_end  = step_end && step_cnt == TW'(STEPS_PER_CHIP - 1);
    assign last_chip = chip_cnt == n_lat - 1'b1;

    // state register; status outputs are registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            lo_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            lo_en <= state_nx == RUN;
            busy  <= state_nx != IDLE;
            done  <= state_nx == DONE;
        end
    end

    // next-state logic; abort overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && n_chips != '0) state_nx = ALIGN;
            ALIGN:   state_nx = RUN;
            RUN:     if (chip_end && last_chip) state_nx = DRAIN;
            DRAIN:   if (!chip_valid || chip_ready) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // sample/step/chip counters, LO phase and chip handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_cnt <= '0;
            step_cnt   <= '0;
            chip_cnt   <= '0;
            n_lat      <= '0;
            lo_phase   <= 2'd0;
            chip_valid <= 1'b0;
            chip_idx   <= '0;
            overrun    <= 1'b0;
        end else if (abort) begin
            chip_valid <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == ALIGN) begin
                n_lat   <= n_chips;
                overrun <= 1'b0;
            end
            if (state == ALIGN) begin
                sample_cnt <= '0;
                step_cnt   <= '0;
                chip_cnt   <= '0;
                lo_phase   <= 2'd0;
            end
            if (integ_en) sample_cnt <= step_end ? '0 : sample_cnt + 1'b1;
            if (step_end) begin
                lo_phase <= lo_phase + 2'd1;
                step_cnt <= chip_end ? '0 : step_cnt + 1'b1;
            end
            if (chip_end) begin
                chip_valid <= 1'b1;
                chip_idx   <= chip_cnt;
                chip_cnt   <= chip_cnt + 1'b1;
                if (chip_valid && !chip_ready) overrun <= 1'b1;
            end else if (chip_valid && chip_ready) begin
                chip_valid <= 1'b0;
            end
        end
    end
endmodule
